// File: rtl/keypad_arbiter_if.sv
// Keypad/core signal bundle for keypad_arbiter. The master side is the pair of
// keypad decoders plus the alarm core; the slave side is the arbiter itself.
interface keypad_arbiter_if;
    logic [1:0] kp0_command;
    logic [3:0] kp0_digit;
    logic       kp0_digit_enterd;
    logic [1:0] kp1_command;
    logic [3:0] kp1_digit;
    logic       kp1_digit_enterd;
    logic       kp0_grant;
    logic       kp1_grant;
    logic       kp0_busy;
    logic       kp1_busy;
    logic [1:0] core_command;
    logic [3:0] core_digit;
    logic       core_digit_enterd;
    logic       timeout;
    logic [2:0] dbg_state;

    modport master (
        output kp0_command, kp0_digit, kp0_digit_enterd,
        output kp1_command, kp1_digit, kp1_digit_enterd,
        input  kp0_grant, kp1_grant, kp0_busy, kp1_busy,
        input  core_command, core_digit, core_digit_enterd, timeout, dbg_state
    );

    modport slave (
        input  kp0_command, kp0_digit, kp0_digit_enterd,
        input  kp1_command, kp1_digit, kp1_digit_enterd,
        output kp0_grant, kp1_grant, kp0_busy, kp1_busy,
        output core_command, core_digit, core_digit_enterd, timeout, dbg_state
    );
endinterface

// File: rtl/keypad_arbiter.sv
// Shares the alarm core's command/digit port between two keypads, one full code
// sequence at a time. Define KEYPAD_TIMEOUT_EN to build the abandoned-entry flush.
module keypad_arbiter #(
    parameter int         DIGITS     = 3,
    parameter int         TIMEOUT    = 1000,
    parameter logic [3:0] FILL_DIGIT = 4'hF
) (
    input logic             clk,
    input logic             reset,
    keypad_arbiter_if.slave bus
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] COUNT_DONE = CW'(DIGITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_DIGITS = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;

    if (DIGITS < 1 || TIMEOUT < 2) begin : g_param_check
        $error("keypad_arbiter: DIGITS must be >= 1 and TIMEOUT >= 2");
    end

    logic [2:0]    state_q, state_d;
    logic          last_q, last_d;      // also the current owner while granted
    logic [CW-1:0] count_q, count_d;
    logic          grant0_q, grant0_d;
    logic          grant1_q, grant1_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [3:0]    digit_q, digit_d;
    logic          stb_q, stb_d;

`ifdef KEYPAD_TIMEOUT_EN
    localparam logic [2:0] ST_FLUSH = 3'd4;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_q, timeout_d;
`endif

    logic       req0, req1, pick;
    logic       own_stb;
    logic [3:0] own_digit;

    assign req0      = (bus.kp0_command == 2'd1) || (bus.kp0_command == 2'd2);
    assign req1      = (bus.kp1_command == 2'd1) || (bus.kp1_command == 2'd2);
    assign pick      = (req0 && req1) ? ~last_q : req1;
    assign own_stb   = last_q ? bus.kp1_digit_enterd : bus.kp0_digit_enterd;
    assign own_digit = last_q ? bus.kp1_digit : bus.kp0_digit;

    // Output registers are loaded with the values of the state being entered,
    // so every output is registered and aligned with state_q.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        count_d  = count_q;
        grant0_d = grant0_q;
        grant1_d = grant1_q;
        cmd_d    = 2'd0;
        digit_d  = digit_q;
        stb_d    = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    last_d   = pick;
                    grant0_d = ~pick;
                    grant1_d = pick;
                    cmd_d    = pick ? bus.kp1_command : bus.kp0_command;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                count_d = '0;
`ifdef KEYPAD_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ST_DIGITS;
            end
            ST_DIGITS: begin
                if (count_q == COUNT_DONE) begin
                    state_d = ST_GAP;
                end else if (own_stb) begin
                    digit_d = own_digit;
                    stb_d   = 1'b1;
                    count_d = count_q + CW'(1);
`ifdef KEYPAD_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
`ifdef KEYPAD_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_FLUSH;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
`ifdef KEYPAD_TIMEOUT_EN
            ST_FLUSH: begin
                if (count_q == COUNT_DONE) begin
                    state_d = ST_GAP;
                end else begin
                    digit_d = FILL_DIGIT;
                    stb_d   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
`endif
            ST_GAP: begin
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                grant0_d = 1'b0;
                grant1_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            count_q  <= '0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            cmd_q    <= 2'd0;
            digit_q  <= 4'd0;
            stb_q    <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            count_q  <= count_d;
            grant0_q <= grant0_d;
            grant1_q <= grant1_d;
            cmd_q    <= cmd_d;
            digit_q  <= digit_d;
            stb_q    <= stb_d;
`ifdef KEYPAD_TIMEOUT_EN
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.kp0_grant         = grant0_q;
    assign bus.kp1_grant         = grant1_q;
    assign bus.kp0_busy          = grant1_q;
    assign bus.kp1_busy          = grant0_q;
    assign bus.core_command      = cmd_q;
    assign bus.core_digit        = digit_q;
    assign bus.core_digit_enterd = stb_q;
    assign bus.dbg_state         = state_q;
`ifdef KEYPAD_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif
endmodule
